// File: rtl/lcd_timing_pkg.sv
// Shared constants and types for the LCD video timing generator:
// 720p default geometry, counter width, colour-bar palette and pipeline records.
package lcd_timing_pkg;

  localparam int CNT_W = 12;

  // 1280x720 @ 74.25 MHz pixel clock
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  // Colour bars, left to right
  localparam int          NUM_BARS    = 8;
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Request stage: one cycle after the counters
  typedef struct packed {
    logic             run;
    logic             req;
    logic             fs;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } stage1_t;

  // Pin stage: one cycle after the request stage
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } stage2_t;

  // Bar index to colour; indices past the last bar (remainder pixels) are black.
  function automatic logic [23:0] bar_colour(input logic [3:0] idx);
    case (idx)
      4'd0:    return BAR_WHITE;
      4'd1:    return BAR_YELLOW;
      4'd2:    return BAR_CYAN;
      4'd3:    return BAR_GREEN;
      4'd4:    return BAR_MAGENTA;
      4'd5:    return BAR_RED;
      4'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// Generic wrap counter for one video axis: counts 0..TOTAL-1 on inc_i,
// forced to 0 by clr_i, tc_o flags the last count.
module lcd_axis_cnt
  import lcd_timing_pkg::*;
#(
  parameter int TOTAL = 1650
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  // Next count: clear wins over increment, increment wraps at the terminal count.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values, independent of block order.
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD/HDMI video timing generator (pixel clock domain).
// Counters -> request stage (pix_req/req_x/req_y/frame_start) -> pin stage
// (lcd_de/hs/vs/rgb). Frames are always completed; en is honoured only at
// the last cycle of a frame or while idle.
// Optional build macro LCD_TIMING_TEST_PATTERN_EN: replace rgb_in with eight
// vertical colour bars on the lcd_r/g/b pins.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic             pix_req,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             frame_start,
  input  logic [23:0]      rgb_in,
  output logic             lcd_de,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic [7:0]       lcd_r,
  output logic [7:0]       lcd_g,
  output logic [7:0]       lcd_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_e           state_q, state_d;
  logic             run;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_tc, v_tc;
  logic             frame_end;
  stage1_t          s1_q, s1_d;
  stage2_t          s2_q, s2_d;
  logic [23:0]      pix_rgb;

  // ---------------------------------------------------------------- counters
  lcd_axis_cnt #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (run),
    .clr_i (!run),
    .cnt_o (h_cnt),
    .tc_o  (h_tc)
  );

  lcd_axis_cnt #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (run && h_tc),
    .clr_i (!run),
    .cnt_o (v_cnt),
    .tc_o  (v_tc)
  );

  assign frame_end = h_tc && v_tc;

  // ---------------------------------------------------------------- control FSM
  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start on en, stop only on the last cycle of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)               state_d = ST_RUN;
      ST_RUN:  if (frame_end && !en) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // FSM output: counters advance only while running.
  always_comb begin
    run = (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------- request stage
  // Decode the counters into a pixel request; everything idles at zero.
  always_comb begin
    s1_d     = '0;
    s1_d.run = run;
    if (run) begin
      s1_d.req = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      s1_d.fs  = (h_cnt == '0) && (v_cnt == '0);
      s1_d.x   = h_cnt;
      s1_d.y   = v_cnt;
    end
  end

  // Request stage register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  assign pix_req     = s1_q.req;
  assign req_x       = s1_q.x;
  assign req_y       = s1_q.y;
  assign frame_start = s1_q.fs;

  // ---------------------------------------------------------------- pixel source
`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam int               BAR_W    = H_ACTIVE / NUM_BARS;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] bar_pix_q, bar_pix_d;
  logic [3:0]       bar_idx_q, bar_idx_d;
  logic             unused_rgb;

  assign unused_rgb = ^rgb_in;

  // Track which bar req_x falls in; restarts at h=0 and saturates past the last bar.
  always_comb begin
    bar_pix_d = '0;
    bar_idx_d = '0;
    if (run && (h_cnt != '0)) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = '0;
        bar_idx_d = (bar_idx_q == 4'(NUM_BARS)) ? bar_idx_q : bar_idx_q + 1'b1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
        bar_idx_d = bar_idx_q;
      end
    end
  end

  // Bar position register, aligned with the request stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_pix_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Bars narrower than one pixel cannot be drawn; show black.
  assign pix_rgb = (BAR_W == 0) ? BAR_BLACK : bar_colour(bar_idx_q);
`else
  assign pix_rgb = rgb_in;
`endif

  // ---------------------------------------------------------------- pin stage
  // Syncs decode the request-stage coordinates so hs/vs/de stay aligned.
  always_comb begin
    s2_d     = '0;
    s2_d.de  = s1_q.req;
    s2_d.hs  = (s1_q.run && (s1_q.x >= HS_START_C) && (s1_q.x < HS_END_C)) ? HS_POL : ~HS_POL;
    s2_d.vs  = (s1_q.run && (s1_q.y >= VS_START_C) && (s1_q.y < VS_END_C)) ? VS_POL : ~VS_POL;
    s2_d.rgb = s1_q.req ? pix_rgb : '0;
  end

  // Pin stage register; syncs rest at their inactive level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_q    <= '0;
      s2_q.hs <= ~HS_POL;
      s2_q.vs <= ~VS_POL;
    end else begin
      s2_q    <= s2_d;
    end
  end

  assign lcd_de = s2_q.de;
  assign lcd_hs = s2_q.hs;
  assign lcd_vs = s2_q.vs;
  assign lcd_r  = s2_q.rgb[23:16];
  assign lcd_g  = s2_q.rgb[15:8];
  assign lcd_b  = s2_q.rgb[7:0];

  // Line and frame totals must fit the counters.
  a_geometry_fits: assert property (@(posedge clk)
    (H_TOTAL < (1 << CNT_W)) && (V_TOTAL < (1 << CNT_W)))
    else $error("lcd_timing_gen: timing totals exceed the counter width");

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen on a small geometry.
// The reference model tracks the linear pixel index within the frame and a
// two-entry delay line of expected outputs; stimulus toggles en and rstn at
// random on top of a few directed scenarios.
module tb_lcd_timing_gen;

`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam int HA = 16;
`else
  localparam int HA = 8;
`endif
  localparam int HF  = 2;
  localparam int HSY = 3;
  localparam int HB  = 3;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 1;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
  localparam int HT    = HA + HF + HSY + HB;
  localparam int VT    = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        pix_req;
  logic [11:0] req_x, req_y;
  logic        frame_start;
  logic [23:0] rgb_in;
  logic        lcd_de, lcd_hs, lcd_vs;
  logic [7:0]  lcd_r, lcd_g, lcd_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: running flag and linear index of the pixel the counters point at.
  bit m_run;
  int m_n;
  // Expected request-stage outputs.
  bit e_run1, e_req, e_fs;
  int e_x, e_y;
  // Expected pin-stage outputs.
  bit          e_de, e_hs, e_vs;
  logic [23:0] e_rgb;

  lcd_timing_gen #(
    .H_ACTIVE (HA),  .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA),  .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .HS_POL   (HS_POL), .VS_POL (VS_POL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .pix_req     (pix_req),
    .req_x       (req_x),
    .req_y       (req_y),
    .frame_start (frame_start),
    .rgb_in      (rgb_in),
    .lcd_de      (lcd_de),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_r       (lcd_r),
    .lcd_g       (lcd_g),
    .lcd_b       (lcd_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Colour the pins must show for pixel (x, y).
  function automatic logic [23:0] pixel_colour(input int x, input int y);
`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int bw = HA / 8;
    if (bw == 0 || x / bw >= 8 || y < 0) return 24'h0;
    return bars[x / bw];
`else
    return {8'(x), 8'(y), 8'h5A};
`endif
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_n    = 0;
    e_run1 = 1'b0;
    e_req  = 1'b0;
    e_fs   = 1'b0;
    e_x    = 0;
    e_y    = 0;
    e_de   = 1'b0;
    e_hs   = !HS_POL;
    e_vs   = !VS_POL;
    e_rgb  = 24'h0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    if (!rstn) begin
      model_reset();
      return;
    end
    e_de  = e_req;
    e_hs  = (e_run1 && e_x >= HA + HF && e_x < HA + HF + HSY) ? HS_POL : !HS_POL;
    e_vs  = (e_run1 && e_y >= VA + VF && e_y < VA + VF + VSY) ? VS_POL : !VS_POL;
    e_rgb = e_req ? pixel_colour(e_x, e_y) : 24'h0;
    if (m_run) begin
      e_run1 = 1'b1;
      e_x    = m_n % HT;
      e_y    = m_n / HT;
      e_req  = (e_x < HA) && (e_y < VA);
      e_fs   = (m_n == 0);
    end else begin
      e_run1 = 1'b0;
      e_x    = 0;
      e_y    = 0;
      e_req  = 1'b0;
      e_fs   = 1'b0;
    end
    if (m_run) begin
      if (m_n == FRAME - 1) begin
        m_n   = 0;
        m_run = en;
      end else begin
        m_n++;
      end
    end else if (en) begin
      m_run = 1'b1;
      m_n   = 0;
    end
  endtask

  task automatic compare_all();
    check("pix_req",     pix_req,     e_req);
    check("req_x",       req_x,       e_x);
    check("req_y",       req_y,       e_y);
    check("frame_start", frame_start, e_fs);
    check("lcd_de",      lcd_de,      e_de);
    check("lcd_hs",      lcd_hs,      e_hs);
    check("lcd_vs",      lcd_vs,      e_vs);
    check("lcd_rgb",     {lcd_r, lcd_g, lcd_b}, e_rgb);
  endtask

  // Upstream source: answers a request one cycle later, noise otherwise.
  task automatic drive_source();
    if (pix_req) rgb_in = {req_x[7:0], req_y[7:0], 8'h5A};
    else         rgb_in = 24'($urandom);
  endtask

  // One clock: model follows the edge, source responds, outputs checked at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_source();
    @(negedge clk);
    compare_all();
  endtask

  // Pulse rstn between edges; outputs must react without a clock edge.
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_act_cnt;
    rstn   = 1'b0;
    en     = 1'b0;
    rgb_in = 24'h0;
    model_reset();

    // Reset, then idle with en low.
    repeat (3) step();
    rstn = 1'b1;
    repeat (4) step();

    // Start and free-run two whole frames, tallying the pins.
    en = 1'b1;
    de_cnt = 0; hs_cnt = 0; vs_act_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step();
      if (lcd_de)           de_cnt++;
      if (lcd_hs == HS_POL) hs_cnt++;
      if (lcd_vs == VS_POL) vs_act_cnt++;
    end
    check("de_per_2_frames", de_cnt,     2 * HA * VA);
    check("hs_per_2_frames", hs_cnt,     2 * VT * HSY);
    check("vs_per_2_frames", vs_act_cnt, 2 * VSY * HT);

    // Drop en at pixel (3, 1): the frame must finish, then stay idle.
    for (int i = 0; i < 2 * FRAME && m_n != HT + 3; i++) step();
    en = 1'b0;
    repeat (FRAME + 6) step();
    en = 1'b1;
    repeat (FRAME + 4) step();

    // Asynchronous reset mid-line, then idle until en returns.
    for (int i = 0; i < 2 * FRAME && (m_n % HT) != 5; i++) step();
    en = 1'b0;
    async_reset();
    repeat (6) step();
    en = 1'b1;
    repeat (HT * 3) step();

    // Random en toggling with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0)  en = !en;
      if ($urandom_range(0, 499) == 0) async_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
